// File: rtl/alu_issue_decoder_pkg.sv
// Shared RV32I decode types: ALU op and branch encodings, opcode/funct constants, decoded-entry layout.
// Used by the issue stage and by the ALU that consumes its outputs.
package alu_issue_decoder_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_SRL  = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_type_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH
  } imm_sel_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t     alucontrol;
    br_type_t    br_type;
    logic        unsign;
    logic        is_branch;
    logic        use_imm;
    logic        use_pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        illegal;
  } dec_t;

  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Fetch-side and execute-side handshake/bus bundle of the issue stage.
// slave is the stage's view; master is the surrounding fetch/execute view.
interface alu_issue_decoder_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [3:0]      o_alucontrol;
  logic [1:0]      o_br_type;
  logic            o_unsign;
  logic            o_is_branch;
  logic            o_use_imm;
  logic            o_use_pc;
  logic [XLEN-1:0] o_imm;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [4:0]      o_rd;
  logic            o_reg_we;
  logic [XLEN-1:0] o_pc;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_alucontrol, o_br_type, o_unsign, o_is_branch,
           o_use_imm, o_use_pc, o_imm, o_rs1, o_rs2, o_rd, o_reg_we, o_pc, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_alucontrol, o_br_type, o_unsign, o_is_branch,
           o_use_imm, o_use_pc, o_imm, o_rs1, o_rs2, o_rd, o_reg_we, o_pc, o_illegal
  );
endinterface

// File: rtl/alu_issue_decoder_imm_gen.sv
// Combinational RV32I immediate select and sign-extend; takes instr[31:7] since opcode is decoded upstream.
// Shift immediates return only the 5-bit shamt, zero-extended.
module alu_issue_decoder_imm_gen
  import alu_issue_decoder_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_sel_t    i_sel,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_sel)
      IMM_I:  o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:  o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:  o_imm = {i_instr[31:12], 12'b0};
      IMM_J:  o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      IMM_SH: o_imm = {27'b0, i_instr[24:20]};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// RV32I decode/issue stage: one-entry registered pipeline feeding the ALU, 1-cycle latency.
// o_ready = ~o_valid | i_ready (no skid); flush drops both the held and the offered entry.
module alu_issue_decoder
  import alu_issue_decoder_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  alu_issue_decoder_if.slave io_if
);

  logic [31:0] w_instr;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  imm_sel_t    w_imm_sel;
  logic [31:0] w_imm;
  logic        w_illegal;
  dec_t        w_ctl;
  dec_t        w_dec;
  logic        w_ready;
  logic        w_load;

  logic            r_valid;
  dec_t            r_entry;
  logic [XLEN-1:0] r_pc;

  assign w_instr = io_if.i_instr;
  assign w_opc   = w_instr[6:0];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];

  alu_issue_decoder_imm_gen u_imm_gen (
    .i_instr (w_instr[31:7]),
    .i_sel   (w_imm_sel),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_ctl     = '0;
    w_imm_sel = IMM_NONE;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_ctl.rs1 = w_instr[19:15]; w_ctl.rs2 = w_instr[24:20];
        w_ctl.rd  = w_instr[11:7];  w_ctl.reg_we = 1'b1;
        if (w_f7 == F7_ZERO)                       w_ctl.alucontrol = alu_op_from_f3(w_f3);
        else if (w_f7 == F7_ALT && w_f3 == F3_ADD) w_ctl.alucontrol = ALU_SUB;
        else if (w_f7 == F7_ALT && w_f3 == F3_SR)  w_ctl.alucontrol = ALU_SRA;
        else                                       w_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctl.rs1 = w_instr[19:15]; w_ctl.rd = w_instr[11:7];
        w_ctl.reg_we = 1'b1; w_ctl.use_imm = 1'b1;
        // Shifts reuse imm[11:5] as a funct7; every other op keeps the full I-immediate.
        if (w_f3 == F3_SLL) begin
          w_imm_sel = IMM_SH; w_ctl.alucontrol = ALU_SLL;
          w_illegal = (w_f7 != F7_ZERO);
        end else if (w_f3 == F3_SR) begin
          w_imm_sel = IMM_SH;
          if (w_f7 == F7_ZERO)     w_ctl.alucontrol = ALU_SRL;
          else if (w_f7 == F7_ALT) w_ctl.alucontrol = ALU_SRA;
          else                     w_illegal = 1'b1;
        end else begin
          w_imm_sel = IMM_I; w_ctl.alucontrol = alu_op_from_f3(w_f3);
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_ctl.rd = w_instr[11:7]; w_ctl.reg_we = 1'b1; w_ctl.use_imm = 1'b1;
        w_ctl.use_pc = (w_opc == OPC_AUIPC); w_imm_sel = IMM_U;
      end
      OPC_LOAD, OPC_JALR: begin
        w_ctl.rs1 = w_instr[19:15]; w_ctl.rd = w_instr[11:7];
        w_ctl.reg_we = 1'b1; w_ctl.use_imm = 1'b1; w_imm_sel = IMM_I;
      end
      OPC_STORE: begin
        w_ctl.rs1 = w_instr[19:15]; w_ctl.rs2 = w_instr[24:20];
        w_ctl.use_imm = 1'b1; w_imm_sel = IMM_S;
      end
      OPC_JAL: begin
        w_ctl.rd = w_instr[11:7]; w_ctl.reg_we = 1'b1;
        w_ctl.use_imm = 1'b1; w_ctl.use_pc = 1'b1; w_imm_sel = IMM_J;
      end
      OPC_BRANCH: begin
        w_ctl.rs1 = w_instr[19:15]; w_ctl.rs2 = w_instr[24:20];
        w_ctl.alucontrol = ALU_SUB; w_ctl.is_branch = 1'b1; w_imm_sel = IMM_B;
        case (w_f3)
          F3_BEQ:  w_ctl.br_type = BR_EQ;
          F3_BNE:  w_ctl.br_type = BR_NE;
          F3_BLT:  w_ctl.br_type = BR_LT;
          F3_BGE:  w_ctl.br_type = BR_GE;
          F3_BLTU: begin w_ctl.br_type = BR_LT; w_ctl.unsign = 1'b1; end
          F3_BGEU: begin w_ctl.br_type = BR_GE; w_ctl.unsign = 1'b1; end
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_ctl.rd == 5'd0) w_ctl.reg_we = 1'b0;
    // Illegal entries still issue, but as an inert add so execute has nothing to act on.
    if (w_illegal) begin
      w_ctl         = '0;
      w_ctl.illegal = 1'b1;
    end
  end

  always_comb begin
    w_dec     = w_ctl;
    w_dec.imm = w_ctl.illegal ? 32'd0 : w_imm;
  end

  assign w_ready = ~r_valid | io_if.i_ready;
  assign w_load  = io_if.i_valid & w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
      r_pc    <= RESET_PC;
    end else if (io_if.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_entry <= w_dec;
      r_pc    <= io_if.i_pc;
    end else if (io_if.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io_if.o_ready      = w_ready;
  assign io_if.o_valid      = r_valid;
  assign io_if.o_alucontrol = r_entry.alucontrol;
  assign io_if.o_br_type    = r_entry.br_type;
  assign io_if.o_unsign     = r_entry.unsign;
  assign io_if.o_is_branch  = r_entry.is_branch;
  assign io_if.o_use_imm    = r_entry.use_imm;
  assign io_if.o_use_pc     = r_entry.use_pc;
  assign io_if.o_imm        = r_entry.imm;
  assign io_if.o_rs1        = r_entry.rs1;
  assign io_if.o_rs2        = r_entry.rs2;
  assign io_if.o_rd         = r_entry.rd;
  assign io_if.o_reg_we     = r_entry.reg_we;
  assign io_if.o_pc         = r_pc;
  assign io_if.o_illegal    = r_entry.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: decode vectors, stall/back-to-back, flush, illegal and async reset.
module tb_alu_issue_decoder;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_issue_decoder_if #(.XLEN(32)) bus ();

  alu_issue_decoder #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.o_valid); end
    checks++; if (bus.o_pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.o_pc, RST_PC); end
    checks++; if (bus.o_imm !== 32'd0) begin failures++; $display("FAIL reset_imm got=%h exp=0", bus.o_imm); end
    checks++; if (bus.o_reg_we !== 1'b0 || bus.o_alucontrol !== 4'd0) begin failures++; $display("FAIL reset_ctl got we=%0b alu=%b exp 0/0000", bus.o_reg_we, bus.o_alucontrol); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.o_ready); end
  endtask

  task automatic test_add();
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'h002081B3; bus.i_pc = 32'h100;
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.o_valid); end
    checks++; if (bus.o_alucontrol !== 4'b0000) begin failures++; $display("FAIL add_alu got=%b exp=0000", bus.o_alucontrol); end
    checks++; if (bus.o_rd !== 5'd3 || bus.o_rs1 !== 5'd1 || bus.o_rs2 !== 5'd2) begin failures++; $display("FAIL add_regs got rd=%0d rs1=%0d rs2=%0d exp 3/1/2", bus.o_rd, bus.o_rs1, bus.o_rs2); end
    checks++; if (bus.o_reg_we !== 1'b1 || bus.o_use_imm !== 1'b0) begin failures++; $display("FAIL add_we got we=%0b imm=%0b exp 1/0", bus.o_reg_we, bus.o_use_imm); end
    checks++; if (bus.o_pc !== 32'h100) begin failures++; $display("FAIL add_pc got=%h exp=100", bus.o_pc); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b exp=0", bus.o_valid); end
  endtask

  task automatic test_srai();
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'h40335293; bus.i_pc = 32'h104;
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_alucontrol !== 4'b1001) begin failures++; $display("FAIL srai_alu got=%b exp=1001", bus.o_alucontrol); end
    checks++; if (bus.o_use_imm !== 1'b1 || bus.o_imm[4:0] !== 5'd3) begin failures++; $display("FAIL srai_imm got use=%0b imm=%h exp 1/shamt 3", bus.o_use_imm, bus.o_imm); end
    checks++; if (bus.o_rd !== 5'd5 || bus.o_rs1 !== 5'd6 || bus.o_illegal !== 1'b0) begin failures++; $display("FAIL srai_regs got rd=%0d rs1=%0d ill=%0b exp 5/6/0", bus.o_rd, bus.o_rs1, bus.o_illegal); end
    tick();
  endtask

  task automatic test_bgeu();
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'hFE20FEE3; bus.i_pc = 32'h108;
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_alucontrol !== 4'b0001) begin failures++; $display("FAIL bgeu_alu got=%b exp=0001", bus.o_alucontrol); end
    checks++; if (bus.o_br_type !== 2'b11 || bus.o_unsign !== 1'b1 || bus.o_is_branch !== 1'b1) begin failures++; $display("FAIL bgeu_br got bt=%b u=%0b br=%0b exp 11/1/1", bus.o_br_type, bus.o_unsign, bus.o_is_branch); end
    checks++; if (bus.o_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL bgeu_imm got=%h exp=fffffffc", bus.o_imm); end
    checks++; if (bus.o_reg_we !== 1'b0 || bus.o_rd !== 5'd0) begin failures++; $display("FAIL bgeu_we got we=%0b rd=%0d exp 0/0", bus.o_reg_we, bus.o_rd); end
    tick();
  endtask

  task automatic test_sub();
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'h402081B3; bus.i_pc = 32'h10C;
    tick();
    bus.i_valid = 1'b0;
    checks++; if (bus.o_alucontrol !== 4'b0001 || bus.o_is_branch !== 1'b0) begin failures++; $display("FAIL sub_alu got alu=%b br=%0b exp 0001/0", bus.o_alucontrol, bus.o_is_branch); end
    tick();
  endtask

  task automatic test_stall();
    bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_instr = 32'h00500093; bus.i_pc = 32'h200;
    tick();
    bus.i_instr = 32'h00700113; bus.i_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%0b exp=0", i, bus.o_ready); end
      checks++; if (bus.o_valid !== 1'b1 || bus.o_rd !== 5'd1 || bus.o_imm !== 32'd5 || bus.o_pc !== 32'h200) begin failures++; $display("FAIL stall_hold cyc=%0d got v=%0b rd=%0d imm=%h pc=%h exp 1/1/5/200", i, bus.o_valid, bus.o_rd, bus.o_imm, bus.o_pc); end
      tick();
    end
    bus.i_ready = 1'b1;
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", bus.o_ready); end
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_rd !== 5'd2 || bus.o_imm !== 32'd7) begin failures++; $display("FAIL b2b_first got v=%0b rd=%0d imm=%h exp 1/2/7", bus.o_valid, bus.o_rd, bus.o_imm); end
    bus.i_instr = 32'h00900193; bus.i_pc = 32'h208;
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_rd !== 5'd3 || bus.o_pc !== 32'h208) begin failures++; $display("FAIL b2b_second got v=%0b rd=%0d pc=%h exp 1/3/208", bus.o_valid, bus.o_rd, bus.o_pc); end
    bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", bus.o_valid); end
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_instr = 32'h00400213; bus.i_pc = 32'h300;
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_rd !== 5'd4) begin failures++; $display("FAIL flush_pre got v=%0b rd=%0d exp 1/4", bus.o_valid, bus.o_rd); end
    bus.i_instr = 32'h00500293; bus.i_pc = 32'h304; bus.i_flush = 1'b1; bus.i_ready = 1'b1;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got=%0b exp=0", bus.o_valid); end
    checks++; if (bus.o_pc !== 32'h300) begin failures++; $display("FAIL flush_drop_pc got=%h exp=300", bus.o_pc); end
    bus.i_flush = 1'b0; bus.i_valid = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%0b exp=0", bus.o_valid); end
  endtask

  task automatic test_illegal();
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'h00000000; bus.i_pc = 32'h400;
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_illegal !== 1'b1 || bus.o_reg_we !== 1'b0) begin failures++; $display("FAIL ill_zero got v=%0b ill=%0b we=%0b exp 1/1/0", bus.o_valid, bus.o_illegal, bus.o_reg_we); end
    bus.i_instr = 32'h022081B3;
    tick();
    checks++; if (bus.o_illegal !== 1'b1 || bus.o_alucontrol !== 4'd0 || bus.o_reg_we !== 1'b0) begin failures++; $display("FAIL ill_f7 got ill=%0b alu=%b we=%0b exp 1/0000/0", bus.o_illegal, bus.o_alucontrol, bus.o_reg_we); end
    bus.i_instr = 32'h0020A063;
    tick();
    checks++; if (bus.o_illegal !== 1'b1 || bus.o_is_branch !== 1'b0) begin failures++; $display("FAIL ill_br got ill=%0b br=%0b exp 1/0", bus.o_illegal, bus.o_is_branch); end
    bus.i_instr = 32'h00000013;
    tick();
    checks++; if (bus.o_illegal !== 1'b0 || bus.o_reg_we !== 1'b0) begin failures++; $display("FAIL nop_x0 got ill=%0b we=%0b exp 0/0", bus.o_illegal, bus.o_reg_we); end
    bus.i_valid = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_stall();
    bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_instr = 32'h00500093; bus.i_pc = 32'h500;
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h500) begin failures++; $display("FAIL rst_pre got v=%0b pc=%h exp 1/500", bus.o_valid, bus.o_pc); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_pc !== RST_PC) begin failures++; $display("FAIL rst_async got v=%0b pc=%h exp 0/%h", bus.o_valid, bus.o_pc, RST_PC); end
    checks++; if (bus.o_rd !== 5'd0 || bus.o_imm !== 32'd0 || bus.o_ready !== 1'b1) begin failures++; $display("FAIL rst_fields got rd=%0d imm=%h rdy=%0b exp 0/0/1", bus.o_rd, bus.o_imm, bus.o_ready); end
    bus.i_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_after got=%0b exp=0", bus.o_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    #12;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_add();
    test_srai();
    test_bgeu();
    test_sub();
    test_stall();
    test_flush();
    test_illegal();
    test_rst_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
